fft_bfly_sched: RTL and testbench
=================================

# fft_bfly_sched

Sequencer for the radix-2 decimation-in-time FFT datapath. It walks every stage and butterfly of an N-point in-place transform. For each butterfly it issues the operand memory reads and the twiddle ROM read, then drives the butterfly add/sub unit's `en` and `sel` with the two-cycle X0/X1 protocol. It also generates the write-back strobes that store X0 and X1 back to their source addresses. It sits between the FFT top-level control and the operand RAM, twiddle ROM, complex multiplier and butterfly add/sub unit.

## Interface
- `LOGN`, default 4: log2 of the transform size; N = 2^LOGN, legal range 2..10.
- `CM_LAT`, default 2: complex-multiplier latency in cycles, measured from the cycle after a twiddle/operand read to valid `cmoutr`/`cmouti`; legal range 1..7.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a transform; honoured only in IDLE.
- `abort` in 1: synchronous cancel; in any non-IDLE state the next state is IDLE and no `done` is produced.
- `busy` out 1: high from the cycle after an accepted `start` through the final WB1 state.
- `done` out 1: one-cycle pulse after the final write-back.
- `stage` out LOGN: current stage index, 0..LOGN-1.
- `rd_en` out 1: operand RAM read strobe; the RAM is a synchronous-read RAM.
- `rd_addr_a` out LOGN: operand RAM read address for the upper butterfly input.
- `rd_addr_b` out LOGN: operand RAM read address for the lower butterfly input.
- `tw_en` out 1: twiddle ROM read strobe.
- `tw_addr` out LOGN-1: twiddle ROM index k, where W = e^(-j2πk/N).
- `bf_en` out 1: butterfly unit `en`.
- `bf_sel` out 1: butterfly unit `sel`. 1 means a trivial twiddle (W=1), so the lower operand bypasses the multiplier.
- `wr_en` out 1: operand RAM write strobe.
- `wr_addr` out LOGN: operand RAM write address.

## Operation
- Input data is stored in bit-reversed order before `start`; output is in natural order.
- For stage s and butterfly k (k = 0..N/2-1):
  - span = 2^s, pos = k mod span, grp = k >> s.
  - a = grp·2·span + pos, b = a + span.
  - tw = pos << (LOGN-1-s).
- Loop order: k increments within a stage; stage increments after k = N/2-1. All arithmetic is unsigned, LOGN bits wide, and never wraps for legal parameters.
- `bf_sel` = 1 exactly when tw = 0.
- FSM states are IDLE, READ, MUL, EXEC, WB0, WB1, DONE.
  - IDLE: on `start`, go to READ with stage = 0 and k = 0.
  - READ: `rd_en` = 1 with addresses a and b. `tw_en` = 1 and `tw_addr` = tw only when tw ≠ 0. Next state is MUL if tw ≠ 0, else EXEC.
  - MUL: holds for exactly CM_LAT cycles (internal down-counter); all strobes low; then EXEC.
  - EXEC: `bf_en` = 1 and `bf_sel` per tw, held stable for this single cycle; then WB0.
  - WB0: `wr_en` = 1 and `wr_addr` = a, capturing the X0 (sum) that the butterfly unit registered at the end of EXEC; then WB1.
  - WB1: `wr_en` = 1 and `wr_addr` = b, capturing X1 (difference).
    - If this was the last butterfly of the last stage, go to DONE.
    - Otherwise advance k/stage and go to READ.
  - DONE: `done` = 1 for one cycle; then IDLE.
- Butterflies are strictly serial; no read overlaps a pending write-back, so there is no RAM read/write hazard.
- Simultaneous `start` and `abort` in IDLE: `start` wins.
- `abort` in any other state: IDLE next cycle, all strobes low, counters cleared.
- `start` while busy is ignored.

## Timing
- Reset (asynchronous assert, active-low): every output is 0, the FSM is in IDLE, and stage, k and the MUL counter are 0. Reset mid-transform discards all progress; no `done` is produced.
- All outputs are registered, decoded from current state and counters, and glitch-free.
- Cycles per butterfly: 4 when tw = 0, and 4 + CM_LAT otherwise.
- Trivial butterflies total 2^LOGN − 1. The transform takes LOGN·N/2·4 + (LOGN·N/2 − N + 1)·CM_LAT cycles of `busy`.
- `done` is asserted in the cycle after the final WB1; `busy` is low in that cycle.

## Test plan
- Reset and idle: hold `reset` = 0 for 3 cycles, then release with no `start` → all outputs stay 0 for 20 cycles.
- LOGN = 4, CM_LAT = 2, pulse `start` → `busy` is high for exactly 162 cycles and `done` pulses once at cycle 163. The trace shows 32 `bf_en` pulses and 64 `wr_en` pulses.
- Address trace, LOGN = 4:
  - Stage 0, k = 3: a = 6, b = 7, tw = 0, `bf_sel` = 1.
  - Stage 2, k = 5: a = 9, b = 13, tw = 2, `bf_sel` = 0.
  - Stage 3, k = 7: a = 7, b = 15, tw = 7.
- Write ordering: for every EXEC cycle, `wr_addr` = a in the next cycle and `wr_addr` = b two cycles later. No `rd_en` occurs between EXEC and WB1.
- Abort and restart:
  - Assert `abort` during stage 1 MUL → IDLE on the next cycle, `busy` = 0, no `done`.
  - A following `start` restarts at stage 0, k = 0 (a = 0, b = 1).
- `start` pulses during busy, `reset` asserted mid-stage 2, and `start` + `abort` together in IDLE:
  - Extra `start` pulses while busy are ignored.
  - `reset` forces outputs to 0 immediately.
  - `start` + `abort` together in IDLE begins a transform.

Source files
------------

// File: rtl/fft_bfly_sched.sv
// Butterfly sequencer for an in-place radix-2 DIT FFT: walks stages/butterflies,
// issues operand/twiddle reads, drives the add/sub unit and the write-back strobes.
//
// state | meaning
// IDLE  | waiting for start
// READ  | operand (and non-trivial twiddle) read issued
// MUL   | waiting CM_LAT cycles for the complex multiplier
// EXEC  | butterfly add/sub enabled
// WB0   | write X0 back to address a
// WB1   | write X1 back to address b, then advance
// DONE  | one-cycle completion pulse
module fft_bfly_sched #(
  parameter int LOGN   = 4,
  parameter int CM_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic            tw_en,
  output logic [LOGN-2:0] tw_addr,
  output logic            bf_en,
  output logic            bf_sel,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr
);

  localparam int KW = LOGN - 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB0  = 3'd4;
  localparam logic [2:0] S_WB1  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [KW-1:0]   k_q, k_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [KW-1:0]   tw_q, tw_d;
  logic [LOGN-1:0] a_d, b_d;
  logic            last_bfly;

  function automatic logic [LOGN-1:0] bfly_a(input logic [LOGN-1:0] s, input logic [KW-1:0] k);
    logic [LOGN-1:0] kk;
    logic [LOGN-1:0] mask;
    kk   = {1'b0, k};
    mask = (LOGN'(1) << s) - LOGN'(1);
    return ((kk >> s) << (s + LOGN'(1))) | (kk & mask);
  endfunction

  function automatic logic [KW-1:0] bfly_tw(input logic [LOGN-1:0] s, input logic [KW-1:0] k);
    logic [KW-1:0] mask;
    mask = (KW'(1) << s) - KW'(1);
    return (k & mask) << (LOGN'(KW) - s);
  endfunction

  assign tw_q      = bfly_tw(stage_q, k_q);
  assign tw_d      = bfly_tw(stage_d, k_d);
  assign a_d       = bfly_a(stage_d, k_d);
  assign b_d       = a_d + (LOGN'(1) << stage_d);
  assign last_bfly = (stage_q == LOGN'(LOGN - 1)) && (&k_q);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          stage_d = '0;
          k_d     = '0;
        end
      end
      S_READ: begin
        if (tw_q != '0) begin
          state_d = S_MUL;
          cnt_d   = 3'(CM_LAT - 1);
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MUL: begin
        if (cnt_q == 3'd0) state_d = S_EXEC;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_EXEC: state_d = S_WB0;
      S_WB0:  state_d = S_WB1;
      S_WB1: begin
        if (last_bfly) begin
          state_d = S_DONE;
          stage_d = '0;
          k_d     = '0;
        end else begin
          state_d = S_READ;
          if (&k_q) begin
            stage_d = stage_q + LOGN'(1);
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort overrides everything except an accepting IDLE
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      stage_d = '0;
      k_d     = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // outputs are registered from the next-state decode so they line up with state_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_en     <= 1'b0;
      tw_addr   <= '0;
      bf_en     <= 1'b0;
      bf_sel    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
    end else begin
      busy      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done      <= (state_d == S_DONE);
      stage     <= stage_d;
      rd_en     <= (state_d == S_READ);
      rd_addr_a <= (state_d == S_READ) ? a_d : '0;
      rd_addr_b <= (state_d == S_READ) ? b_d : '0;
      tw_en     <= (state_d == S_READ) && (tw_d != '0);
      tw_addr   <= (state_d == S_READ) ? tw_d : '0;
      bf_en     <= (state_d == S_EXEC);
      bf_sel    <= (state_d == S_EXEC) && (tw_d == '0);
      wr_en     <= (state_d == S_WB0) || (state_d == S_WB1);
      wr_addr   <= (state_d == S_WB0) ? a_d :
                   (state_d == S_WB1) ? b_d : '0;
    end
  end

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed cycle-by-cycle check of fft_bfly_sched at LOGN=4, CM_LAT=2.
module tb_fft_bfly_sched;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic       busy, done, rd_en, tw_en, bf_en, bf_sel, wr_en;
  logic [3:0] stage, rd_addr_a, rd_addr_b, wr_addr;
  logic [2:0] tw_addr;
  logic [25:0] obs;

  int n_asrt = 0;
  int n_fail = 0;
  int run_cyc, busy_cnt, done_cnt, done_cyc, bfen_cnt, wren_cnt;

  fft_bfly_sched #(.LOGN(4), .CM_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_en(tw_en), .tw_addr(tw_addr),
    .bf_en(bf_en), .bf_sel(bf_sel), .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_en, tw_addr,
                bf_en, bf_sel, wr_en, wr_addr};

  function automatic logic [25:0] pk(bit b, bit d, int st, bit rd, int ra, int rb,
                                     bit twe, int twa, bit bfe, bit bfs, bit wre, int wa);
    return {b, d, 4'(st), rd, 4'(ra), 4'(rb), twe, 3'(twa), bfe, bfs, wre, 4'(wa)};
  endfunction

  // reference address generator, N = 16 so 8 butterflies per stage
  function automatic int bf_a(int i);
    int s, k, span;
    s = i / 8; k = i % 8; span = 1 << s;
    return (k / span) * 2 * span + (k % span);
  endfunction

  function automatic int bf_tw(int i);
    int s, k, span;
    s = i / 8; k = i % 8; span = 1 << s;
    return (k % span) << (3 - s);
  endfunction

  task automatic check(input string tag, input logic [25:0] o, input logic [25:0] e);
    n_asrt++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic clear_counts();
    run_cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; bfen_cnt = 0; wren_cnt = 0;
  endtask

  task automatic expect_cycle(input logic [25:0] e, input string tag);
    check(tag, obs, e);
    run_cyc++;
    if (busy)  busy_cnt++;
    if (done) begin done_cnt++; done_cyc = run_cyc; end
    if (bf_en) bfen_cnt++;
    if (wr_en) wren_cnt++;
    @(negedge clk);
  endtask

  task automatic walk(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int s, a, b, tw;
      s = i / 8; a = bf_a(i); b = a + (1 << s); tw = bf_tw(i);
      if (i == 3) begin
        check("s0k3_a", 26'(rd_addr_a), 26'd6);
        check("s0k3_b", 26'(rd_addr_b), 26'd7);
        check("s0k3_twen", 26'(tw_en), 26'd0);
      end
      if (i == 21) begin
        check("s2k5_a", 26'(rd_addr_a), 26'd9);
        check("s2k5_b", 26'(rd_addr_b), 26'd13);
        check("s2k5_tw", 26'(tw_addr), 26'd2);
      end
      if (i == 31) begin
        check("s3k7_a", 26'(rd_addr_a), 26'd7);
        check("s3k7_b", 26'(rd_addr_b), 26'd15);
        check("s3k7_tw", 26'(tw_addr), 26'd7);
      end
      expect_cycle(pk(1, 0, s, 1, a, b, tw != 0, tw, 0, 0, 0, 0), "read");
      if (tw != 0)
        for (int m = 0; m < 2; m++) expect_cycle(pk(1, 0, s, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mul");
      if (i == 3)  check("s0k3_sel", 26'(bf_sel), 26'd1);
      if (i == 21) check("s2k5_sel", 26'(bf_sel), 26'd0);
      expect_cycle(pk(1, 0, s, 0, 0, 0, 0, 0, 1, tw == 0, 0, 0), "exec");
      expect_cycle(pk(1, 0, s, 0, 0, 0, 0, 0, 0, 0, 1, a), "wb0");
      expect_cycle(pk(1, 0, s, 0, 0, 0, 0, 0, 0, 0, 1, b), "wb1");
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) expect_cycle('0, "reset_hold");
    reset = 1'b1;
    for (int i = 0; i < 20; i++) expect_cycle('0, "idle");

    // full transform
    clear_counts();
    start = 1'b1; @(negedge clk); start = 1'b0;
    walk(0, 31);
    expect_cycle(pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "done");
    expect_cycle('0, "idle_after_done");
    check("busy_cycles", 26'(busy_cnt), 26'd162);
    check("done_count", 26'(done_cnt), 26'd1);
    check("done_cycle", 26'(done_cyc), 26'd163);
    check("bf_en_pulses", 26'(bfen_cnt), 26'd32);
    check("wr_en_pulses", 26'(wren_cnt), 26'd64);

    // abort during stage 1 MUL
    start = 1'b1; @(negedge clk); start = 1'b0;
    walk(0, 8);
    expect_cycle(pk(1, 0, 1, 1, 1, 3, 1, 4, 0, 0, 0, 0), "s1k1_read");
    check("s1k1_mul", obs, pk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    clear_counts();
    for (int i = 0; i < 5; i++) expect_cycle('0, "after_abort");
    check("abort_no_done", 26'(done_cnt), 26'd0);

    // restart, ignored start pulses while busy, then reset in stage 2
    start = 1'b1; @(negedge clk); start = 1'b0;
    walk(0, 0);
    start = 1'b1;
    walk(1, 4);
    start = 1'b0;
    walk(5, 16);
    reset = 1'b0;
    #1;
    check("reset_async", obs, '0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) expect_cycle('0, "reset_mid");
    reset = 1'b1;
    clear_counts();
    for (int i = 0; i < 3; i++) expect_cycle('0, "after_reset");
    check("reset_no_done", 26'(done_cnt), 26'd0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0;
    walk(0, 0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    for (int i = 0; i < 2; i++) expect_cycle('0, "idle_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
